mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes the execute stage's address, writeback value and the 46-bit decode net, plus rs2 as store data.
- Loads/stores: performs one word-aligned bus transaction with byte-lane steering, sign/zero extension and a bus timeout.
- Non-memory instructions: passes the execute result through.
- Presents the final writeback value to the register-file write stage with a one-cycle done pulse.

---
 rtl/mem_stage_pkg.sv | 45 ++++
 rtl/mem_lane_fmt.sv | 57 +++++
 rtl/mem_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// mem_stage_pkg : decode bit indices, FSM encodings and strobe constants
// Revision      : 1.0
// ============================================================================
package mem_stage_pkg;

   localparam int DECODE_W = 46;

   // Instruction decode net bit positions, shared with the decode stage.
   localparam int IS_ADD = 0;
   localparam int IS_LB  = 10;
   localparam int IS_LH  = 11;
   localparam int IS_LW  = 12;
   localparam int IS_LBU = 13;
   localparam int IS_LHU = 14;
   localparam int IS_SB  = 15;
   localparam int IS_SH  = 16;
   localparam int IS_SW  = 17;

   localparam logic [1:0] MEM_ST_IDLE   = 2'd0;
   localparam logic [1:0] MEM_ST_ACCESS = 2'd1;
   localparam logic [1:0] MEM_ST_DONE   = 2'd2;

   localparam logic [3:0] MEM_STRB_NONE    = 4'b0000;
   localparam logic [3:0] MEM_STRB_BYTE0   = 4'b0001;
   localparam logic [3:0] MEM_STRB_LO_HALF = 4'b0011;
   localparam logic [3:0] MEM_STRB_HI_HALF = 4'b1100;
   localparam logic [3:0] MEM_STRB_WORD    = 4'b1111;

   // Latched memory-operation attributes; word size is implied by neither b nor h.
   typedef struct packed {
      logic store;
      logic size_b;
      logic size_h;
      logic unsigned_ld;
   } mem_op_t;

   function automatic logic mem_misaligned(input logic size_h, input logic size_w,
                                           input logic [1:0] addr_lo);
      return (size_h & addr_lo[0]) | (size_w & (addr_lo != 2'b00));
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_fmt.sv
`default_nettype none
// ============================================================================
// mem_lane_fmt : store byte-lane steering and load extract / extension
// Revision     : 1.0
// ============================================================================
module mem_lane_fmt
   import mem_stage_pkg::*;
(
   input  logic        is_store,
   input  logic        size_b,
   input  logic        size_h,
   input  logic        unsigned_ld,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] load_value
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      wdata = store_data;
      if (size_b)
         wdata = {4{store_data[7:0]}};
      else if (size_h)
         wdata = {2{store_data[15:0]}};
   end

   always_comb begin
      wstrb = MEM_STRB_NONE;
      if (is_store) begin
         if (size_b)
            wstrb = MEM_STRB_BYTE0 << addr_lo;
         else if (size_h)
            wstrb = addr_lo[1] ? MEM_STRB_HI_HALF : MEM_STRB_LO_HALF;
         else
            wstrb = MEM_STRB_WORD;
      end
   end

   // Misaligned halves/words simply use the lane the low address bits point at.
   assign w_byte = rdata[{addr_lo, 3'b000} +: 8];
   assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      load_value = rdata;
      if (size_b)
         load_value = unsigned_ld ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      else if (size_h)
         load_value = unsigned_ld ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : memory-access stage, one bus transaction per load/store
//             optional misalignment trap: MEM_MISALIGN_TRAP_EN
// Revision  : 1.0
// ============================================================================
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [DECODE_W-1:0] decode_net_i,
   input  logic [31:0]         address_i,
   input  logic [31:0]         exec_value_i,
   input  logic [31:0]         store_data_i,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [31:0]         mem_addr_o,
   output logic [31:0]         mem_wdata_o,
   output logic [3:0]          mem_wstrb_o,
   input  logic                mem_ack_i,
   input  logic [31:0]         mem_rdata_i,
   output logic                done_o,
   output logic [31:0]         writeback_value_o,
   output logic                bus_err_o,
   output logic                misaligned_o
);

   localparam logic [15:0] c_TIMEOUT_LAST = 16'(BUS_TIMEOUT - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_next_state;
   mem_op_t     r_op;
   mem_op_t     w_dec_op;
   logic [31:0] r_addr;
   logic [31:0] r_store_data;
   logic [15:0] r_wait_cnt;
   logic [31:0] r_wb;
   logic        r_bus_err;
   logic        r_misaligned;
   logic        w_is_mem;
   logic        w_misalign;
   logic        w_timeout;
   logic [31:0] w_wdata;
   logic [3:0]  w_wstrb;
   logic [31:0] w_load_value;
   logic        w_unused_decode;

   assign w_unused_decode = ^decode_net_i;

   assign w_dec_op.store       = decode_net_i[IS_SB] | decode_net_i[IS_SH] | decode_net_i[IS_SW];
   assign w_dec_op.size_b      = decode_net_i[IS_LB] | decode_net_i[IS_LBU] | decode_net_i[IS_SB];
   assign w_dec_op.size_h      = decode_net_i[IS_LH] | decode_net_i[IS_LHU] | decode_net_i[IS_SH];
   assign w_dec_op.unsigned_ld = decode_net_i[IS_LBU] | decode_net_i[IS_LHU];
   assign w_is_mem = w_dec_op.store | decode_net_i[IS_LB] | decode_net_i[IS_LH]
                   | decode_net_i[IS_LW] | decode_net_i[IS_LBU] | decode_net_i[IS_LHU];

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_misalign = w_is_mem & mem_misaligned(w_dec_op.size_h,
                                                 decode_net_i[IS_LW] | decode_net_i[IS_SW],
                                                 address_i[1:0]);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_timeout = (r_wait_cnt == c_TIMEOUT_LAST);

   mem_lane_fmt u_lane_fmt (
      .is_store    (r_op.store),
      .size_b      (r_op.size_b),
      .size_h      (r_op.size_h),
      .unsigned_ld (r_op.unsigned_ld),
      .addr_lo     (r_addr[1:0]),
      .store_data  (r_store_data),
      .rdata       (mem_rdata_i),
      .wdata       (w_wdata),
      .wstrb       (w_wstrb),
      .load_value  (w_load_value)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_state <= MEM_ST_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         MEM_ST_IDLE:
            if (start_i)
               w_next_state = (w_is_mem && !w_misalign) ? MEM_ST_ACCESS : MEM_ST_DONE;
         MEM_ST_ACCESS:
            if (mem_ack_i || w_timeout)
               w_next_state = MEM_ST_DONE;
         MEM_ST_DONE:
            w_next_state = MEM_ST_IDLE;
         default:
            w_next_state = MEM_ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      mem_wstrb_o = MEM_STRB_NONE;
      done_o      = 1'b0;
      case (r_state)
         MEM_ST_ACCESS: begin
            mem_req_o   = 1'b1;
            mem_we_o    = r_op.store;
            mem_addr_o  = {r_addr[31:2], 2'b00};
            mem_wdata_o = w_wdata;
            mem_wstrb_o = w_wstrb;
         end
         MEM_ST_DONE:
            done_o = 1'b1;
         default: ;
      endcase
   end

   // Operand latches and result registers; results change only on entry to DONE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_op         <= '0;
         r_addr       <= 32'h0;
         r_store_data <= 32'h0;
         r_wait_cnt   <= 16'h0;
         r_wb         <= 32'h0;
         r_bus_err    <= 1'b0;
         r_misaligned <= 1'b0;
      end else begin
         case (r_state)
            MEM_ST_IDLE:
               if (start_i) begin
                  r_op         <= w_dec_op;
                  r_addr       <= address_i;
                  r_store_data <= store_data_i;
                  r_wait_cnt   <= 16'h0;
                  if (!w_is_mem || w_misalign) begin
                     r_wb         <= w_misalign ? 32'h0 : exec_value_i;
                     r_bus_err    <= 1'b0;
                     r_misaligned <= w_misalign;
                  end
               end
            MEM_ST_ACCESS:
               if (mem_ack_i) begin
                  r_wb         <= r_op.store ? 32'h0 : w_load_value;
                  r_bus_err    <= 1'b0;
                  r_misaligned <= 1'b0;
               end else if (w_timeout) begin
                  r_wb         <= 32'h0;
                  r_bus_err    <= 1'b1;
                  r_misaligned <= 1'b0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'h1;
               end
            default: ;
         endcase
      end
   end

   assign writeback_value_o = r_wb;
   assign bus_err_o         = r_bus_err;
   assign misaligned_o      = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : directed self-checking bench for mem_stage (BUS_TIMEOUT = 4)
// Revision     : 1.0
// ============================================================================
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic                clk = 1'b0;
   logic                rst_i;
   logic                start_i;
   logic [DECODE_W-1:0] decode_net_i;
   logic [31:0]         address_i;
   logic [31:0]         exec_value_i;
   logic [31:0]         store_data_i;
   logic                mem_req_o;
   logic                mem_we_o;
   logic [31:0]         mem_addr_o;
   logic [31:0]         mem_wdata_o;
   logic [3:0]          mem_wstrb_o;
   logic                mem_ack_i;
   logic [31:0]         mem_rdata_i;
   logic                done_o;
   logic [31:0]         writeback_value_o;
   logic                bus_err_o;
   logic                misaligned_o;

   int total = 0;
   int bad   = 0;

   mem_stage #(.BUS_TIMEOUT(4)) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .start_i           (start_i),
      .decode_net_i      (decode_net_i),
      .address_i         (address_i),
      .exec_value_i      (exec_value_i),
      .store_data_i      (store_data_i),
      .mem_req_o         (mem_req_o),
      .mem_we_o          (mem_we_o),
      .mem_addr_o        (mem_addr_o),
      .mem_wdata_o       (mem_wdata_o),
      .mem_wstrb_o       (mem_wstrb_o),
      .mem_ack_i         (mem_ack_i),
      .mem_rdata_i       (mem_rdata_i),
      .done_o            (done_o),
      .writeback_value_o (writeback_value_o),
      .bus_err_o         (bus_err_o),
      .misaligned_o      (misaligned_o)
   );

   always #5 clk = ~clk;

   // Pulse start for one cycle from IDLE; returns 1 ns after the capturing edge (+1).
   task automatic issue(input int idx, input logic [31:0] addr,
                        input logic [31:0] ev, input logic [31:0] sd);
      @(posedge clk);
      @(negedge clk);
      decode_net_i = DECODE_W'(1) << idx;
      address_i    = addr;
      exec_value_i = ev;
      store_data_i = sd;
      start_i      = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({mem_req_o, mem_we_o, mem_wstrb_o, done_o, bus_err_o, misaligned_o} !== 9'h0) begin
         bad++;
         $display("FAIL reset_flags got=%b want=0", {mem_req_o, mem_we_o, mem_wstrb_o, done_o, bus_err_o, misaligned_o});
      end
      total++;
      if ({mem_addr_o, mem_wdata_o, writeback_value_o} !== 96'h0) begin
         bad++;
         $display("FAIL reset_data got=%h %h %h want=0", mem_addr_o, mem_wdata_o, writeback_value_o);
      end
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   task automatic test_passthrough();
      issue(IS_ADD, 32'h0000_0040, 32'h0000_1234, 32'h0);
      total++;
      if ({done_o, mem_req_o} !== 2'b10) begin
         bad++;
         $display("FAIL add_done_req got=%b want=10", {done_o, mem_req_o});
      end
      total++;
      if (writeback_value_o !== 32'h0000_1234) begin
         bad++;
         $display("FAIL add_wb got=%h want=00001234", writeback_value_o);
      end
      @(posedge clk);
      #1;
      total++;
      if ({done_o, mem_req_o, writeback_value_o} !== {2'b00, 32'h0000_1234}) begin
         bad++;
         $display("FAIL add_after got=%b %h want=00 00001234", {done_o, mem_req_o}, writeback_value_o);
      end
   endtask

   task automatic test_store_byte();
      issue(IS_SB, 32'h0000_0103, 32'h5555_5555, 32'hAABB_CCDD);
      total++;
      if ({mem_req_o, mem_we_o, mem_wstrb_o, done_o} !== 7'b1_1_1000_0) begin
         bad++;
         $display("FAIL sb_ctrl got=%b want=1110000", {mem_req_o, mem_we_o, mem_wstrb_o, done_o});
      end
      total++;
      if ({mem_addr_o, mem_wdata_o} !== {32'h0000_0100, 32'hDDDD_DDDD}) begin
         bad++;
         $display("FAIL sb_addr_data got=%h %h want=00000100 dddddddd", mem_addr_o, mem_wdata_o);
      end
      mem_ack_i = 1'b1;
      @(posedge clk);
      #1 mem_ack_i = 1'b0;
      total++;
      if ({done_o, mem_req_o, bus_err_o, writeback_value_o} !== {3'b100, 32'h0}) begin
         bad++;
         $display("FAIL sb_done got=%b %h want=100 00000000", {done_o, mem_req_o, bus_err_o}, writeback_value_o);
      end
   endtask

   // Byte loads with three wait cycles and a stray start_i during ACCESS.
   task automatic test_load_wait();
      int          idx [2] = '{IS_LB, IS_LBU};
      logic [31:0] exp [2] = '{32'hFFFF_FF80, 32'h0000_0080};
      for (int k = 0; k < 2; k++) begin
         issue(idx[k], 32'h0000_0102, 32'h0, 32'h0);
         total++;
         if ({mem_req_o, mem_we_o, mem_wstrb_o, mem_addr_o} !== {6'b10_0000, 32'h0000_0100}) begin
            bad++;
            $display("FAIL lb%0d_req got=%b %h want=100000 00000100", k, {mem_req_o, mem_we_o, mem_wstrb_o}, mem_addr_o);
         end
         @(posedge clk);
         #1;
         decode_net_i = DECODE_W'(1) << IS_ADD;
         exec_value_i = 32'hDEAD_BEEF;
         start_i      = 1'b1;
         @(posedge clk);
         #1 start_i = 1'b0;
         @(posedge clk);
         #1;
         total++;
         if ({mem_req_o, done_o, mem_addr_o} !== {2'b10, 32'h0000_0100}) begin
            bad++;
            $display("FAIL lb%0d_wait got=%b %h want=10 00000100", k, {mem_req_o, done_o}, mem_addr_o);
         end
         mem_rdata_i = 32'h0080_FF00;
         mem_ack_i   = 1'b1;
         @(posedge clk);
         #1 mem_ack_i = 1'b0;
         total++;
         if ({done_o, writeback_value_o} !== {1'b1, exp[k]}) begin
            bad++;
            $display("FAIL lb%0d_result got=%b %h want=1 %h", k, done_o, writeback_value_o, exp[k]);
         end
      end
   endtask

   task automatic test_load_half_word();
      int          idx  [3] = '{IS_LH, IS_LHU, IS_LW};
      logic [31:0] addr [3] = '{32'h0000_0202, 32'h0000_0202, 32'h0000_0200};
      logic [31:0] exp  [3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_1234};
      for (int k = 0; k < 3; k++) begin
         issue(idx[k], addr[k], 32'h0, 32'h0);
         mem_rdata_i = 32'h8001_1234;
         mem_ack_i   = 1'b1;
         @(posedge clk);
         #1 mem_ack_i = 1'b0;
         total++;
         if ({done_o, writeback_value_o} !== {1'b1, exp[k]}) begin
            bad++;
            $display("FAIL lhw%0d_result got=%b %h want=1 %h", k, done_o, writeback_value_o, exp[k]);
         end
      end
   endtask

   task automatic test_timeout();
      issue(IS_LW, 32'h0000_0300, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({mem_req_o, done_o} !== 2'b10) begin
         bad++;
         $display("FAIL to_fourth got=%b want=10", {mem_req_o, done_o});
      end
      @(posedge clk);
      #1;
      total++;
      if ({done_o, bus_err_o, mem_req_o, writeback_value_o} !== {3'b110, 32'h0}) begin
         bad++;
         $display("FAIL to_done got=%b %h want=110 00000000", {done_o, bus_err_o, mem_req_o}, writeback_value_o);
      end
      @(posedge clk);
      #1;
      total++;
      if ({done_o, bus_err_o} !== 2'b01) begin
         bad++;
         $display("FAIL to_hold got=%b want=01", {done_o, bus_err_o});
      end
   endtask

   task automatic test_reset_mid_access();
      issue(IS_LW, 32'h0000_0400, 32'h0, 32'h0);
      total++;
      if (mem_req_o !== 1'b1) begin
         bad++;
         $display("FAIL rma_req got=%b want=1", mem_req_o);
      end
      #2 rst_i = 1'b1;
      #1;
      total++;
      if ({mem_req_o, done_o, bus_err_o} !== 3'b000) begin
         bad++;
         $display("FAIL rma_async got=%b want=000", {mem_req_o, done_o, bus_err_o});
      end
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   task automatic test_misaligned();
      issue(IS_SW, 32'h0000_0101, 32'h0, 32'h1122_3344);
`ifdef MEM_MISALIGN_TRAP_EN
      total++;
      if ({done_o, misaligned_o, mem_req_o, writeback_value_o} !== {3'b110, 32'h0}) begin
         bad++;
         $display("FAIL mis_trap got=%b %h want=110 00000000", {done_o, misaligned_o, mem_req_o}, writeback_value_o);
      end
`else
      total++;
      if ({mem_req_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_wdata_o} !== {6'b11_1111, 32'h0000_0100, 32'h1122_3344}) begin
         bad++;
         $display("FAIL mis_trunc got=%b %h %h want=111111 00000100 11223344", {mem_req_o, mem_we_o, mem_wstrb_o}, mem_addr_o, mem_wdata_o);
      end
      mem_ack_i = 1'b1;
      @(posedge clk);
      #1 mem_ack_i = 1'b0;
      total++;
      if ({done_o, misaligned_o, writeback_value_o} !== {2'b10, 32'h0}) begin
         bad++;
         $display("FAIL mis_done got=%b %h want=10 00000000", {done_o, misaligned_o}, writeback_value_o);
      end
`endif
   endtask

   initial begin
      start_i      = 1'b0;
      decode_net_i = '0;
      address_i    = 32'h0;
      exec_value_i = 32'h0;
      store_data_i = 32'h0;
      mem_ack_i    = 1'b0;
      mem_rdata_i  = 32'h0;
      test_reset();
      test_passthrough();
      test_store_byte();
      test_load_wait();
      test_load_half_word();
      test_timeout();
      test_reset_mid_access();
      test_misaligned();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
